sprite_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing the sprite controller register port among NREQ

---
 rtl/sprite_bus_arbiter_if.sv | 52 +++++
 rtl/sprite_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sprite_bus_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_bus_arbiter_if.sv
// Wishbone request/response types and the arbiter's bus bundle.
// master modport: requester/slave environment side; slave modport: arbiter side.
// All handshake signals for NREQ masters plus the single downstream slave port.

package sprite_bus_pkg;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [1:0]  bte;
    logic [2:0]  cti;
  } wb_write_request32_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } wb_read_response32_t;

endpackage

interface sprite_bus_arbiter_if #(
  parameter int NREQ = 4
);
  import sprite_bus_pkg::*;

  wb_write_request32_t [NREQ-1:0] m_req;
  wb_read_response32_t [NREQ-1:0] m_resp;
  logic                           s_cs;
  wb_write_request32_t            s_req;
  wb_read_response32_t            s_resp;
  logic [NREQ-1:0]                gnt;
  logic                           busy;

  modport master (
    output m_req, s_resp,
    input  m_resp, s_cs, s_req, gnt, busy
  );

  modport slave (
    input  m_req, s_resp,
    output m_resp, s_cs, s_req, gnt, busy
  );

endinterface

// File: rtl/sprite_bus_arbiter.sv
// Round-robin arbiter: NREQ Wishbone masters onto the sprite controller slave port.
// Latency: slave sees a request 1 clk after cyc; response routed combinationally.
// Losers hold cyc until granted; no new grant until the winner drops cyc.
// Optional ack timeout enabled by defining SPRITE_ARB_TIMEOUT_EN.

module sprite_bus_arbiter
  import sprite_bus_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  sprite_bus_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam wb_write_request32_t REQ_RST = '{
    cyc: 1'b0, stb: 1'b0, we: 1'b0, sel: 4'h0, adr: 32'h0, dat: 32'h0,
    bte: BTE_LINEAR, cti: CTI_CLASSIC
  };

  // Reject configurations the pointer arithmetic and 8-bit counter cannot hold.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("sprite_bus_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]       win_q, win_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  wb_write_request32_t sreq_q, sreq_d;
  logic                cs_q, cs_d;
  logic                rsp_ack, rsp_err;
  logic                any_req;
  logic [IW-1:0]       pick;
  int                  rr_idx;
  wb_read_response32_t [NREQ-1:0] resp;

`ifdef SPRITE_ARB_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       tmo_hit;
  assign tmo_hit = (tmo_q == 8'(TIMEOUT));
`endif

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to ptr (offset 0) is the last writer and wins.
  always_comb begin
    any_req = 1'b0;
    pick    = ptr_q;
    rr_idx  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_idx = (int'(ptr_q) + k) % NREQ;
      if (bus.m_req[rr_idx].cyc) begin
        any_req = 1'b1;
        pick    = IW'(rr_idx);
      end
    end
  end

  // Next-state and datapath: arbitrate in IDLE, follow the winner in GRANT,
  // wait for the winner to let go of cyc in RELEASE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    sreq_d  = sreq_q;
    cs_d    = cs_q;
    rsp_ack = 1'b0;
    rsp_err = 1'b0;
`ifdef SPRITE_ARB_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = NREQ'(1) << pick;
          win_d   = pick;
          ptr_d   = IW'((int'(pick) + 1) % NREQ);
          sreq_d  = bus.m_req[pick];
          cs_d    = 1'b1;
          state_d = GRANT;
`ifdef SPRITE_ARB_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (!bus.m_req[win_q].cyc) begin
          // Master abandoned the cycle: drop the slave, no response.
          sreq_d.cyc = 1'b0;
          sreq_d.stb = 1'b0;
          sreq_d.we  = 1'b0;
          cs_d       = 1'b0;
          gnt_d      = '0;
          state_d    = IDLE;
        end else if (bus.s_resp.ack || bus.s_resp.err) begin
          rsp_ack    = bus.s_resp.ack;
          rsp_err    = bus.s_resp.err;
          sreq_d.cyc = 1'b0;
          sreq_d.stb = 1'b0;
          sreq_d.we  = 1'b0;
          cs_d       = 1'b0;
          state_d    = RELEASE;
`ifdef SPRITE_ARB_TIMEOUT_EN
        end else if (tmo_hit) begin
          // Slave never answered: report a bus error to the winner.
          rsp_err    = 1'b1;
          sreq_d.cyc = 1'b0;
          sreq_d.stb = 1'b0;
          sreq_d.we  = 1'b0;
          cs_d       = 1'b0;
          state_d    = RELEASE;
`endif
        end else begin
          sreq_d = bus.m_req[win_q];
`ifdef SPRITE_ARB_TIMEOUT_EN
          tmo_d  = tmo_q + 8'd1;
`endif
        end
      end
      RELEASE: begin
        if (!bus.m_req[win_q].cyc) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        cs_d    = 1'b0;
        sreq_d  = REQ_RST;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      sreq_q  <= REQ_RST;
      cs_q    <= 1'b0;
`ifdef SPRITE_ARB_TIMEOUT_EN
      tmo_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      sreq_q  <= sreq_d;
      cs_q    <= cs_d;
`ifdef SPRITE_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Response fan-out: read data goes to everyone, ack/err only to the winner.
  always_comb begin
    resp = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp[i].dat = bus.s_resp.dat;
      resp[i].ack = rsp_ack & gnt_q[i];
      resp[i].err = rsp_err & gnt_q[i];
    end
  end

  assign bus.m_resp = resp;
  assign bus.s_cs   = cs_q;
  assign bus.s_req  = sreq_q;
  assign bus.gnt    = gnt_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_bus_arbiter.sv
// Directed bench for sprite_bus_arbiter: reset, single write, round-robin order,
// delayed ack, abort, async reset mid-grant, timeout (macro) or indefinite wait.
module tb_sprite_bus_arbiter;
  import sprite_bus_pkg::*;

  logic clk;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  sprite_bus_arbiter_if #(.NREQ(4)) bus ();

  sprite_bus_arbiter #(.NREQ(4), .TIMEOUT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [3:0] ack_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = bus.m_resp[i].ack;
    return v;
  endfunction

  function automatic logic [3:0] err_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = bus.m_resp[i].err;
    return v;
  endfunction

  task automatic set_req(input int i, input logic [31:0] adr, input logic [31:0] dat);
    bus.m_req[i] = '{cyc: 1'b1, stb: 1'b1, we: 1'b1, sel: 4'hF, adr: adr, dat: dat,
                     bte: BTE_LINEAR, cti: CTI_CLASSIC};
  endtask

  task automatic drop(input int i);
    bus.m_req[i].cyc = 1'b0;
    bus.m_req[i].stb = 1'b0;
  endtask

  // From IDLE with master idx requesting: grant, ack, release.
  task automatic serve(input int idx);
    logic [3:0] exp_vec;
    exp_vec = 4'b0001 << idx;
    step();
    chk("rr_gnt", bus.gnt, exp_vec);
    chk("rr_adr", bus.s_req.adr, 32'h100 + idx);
    bus.s_resp.ack = 1'b1;
    #1;
    chk("rr_ack_route", ack_vec(), exp_vec);
    step();
    bus.s_resp.ack = 1'b0;
    drop(idx);
    step();
    chk("rr_release", bus.gnt, 4'b0000);
  endtask

  initial begin
    rst        = 1'b1;
    bus.m_req  = '0;
    bus.s_resp = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_gnt",  bus.gnt, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cs",   bus.s_cs, 1'b0);
    chk("rst_cyc",  bus.s_req.cyc, 1'b0);
    chk("rst_bte",  bus.s_req.bte, 2'b00);
    chk("rst_cti",  bus.s_req.cti, 3'b000);
    chk("rst_ack",  ack_vec(), 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single write from master 0
    set_req(0, 32'h010, 32'h00640C8);
    #1;
    chk("t1_cyc_not_yet", bus.s_req.cyc, 1'b0);
    step();
    chk("t1_cyc",  bus.s_req.cyc, 1'b1);
    chk("t1_cs",   bus.s_cs, 1'b1);
    chk("t1_adr",  bus.s_req.adr, 32'h010);
    chk("t1_dat",  bus.s_req.dat, 32'h00640C8);
    chk("t1_gnt",  bus.gnt, 4'b0001);
    chk("t1_busy", bus.busy, 1'b1);
    chk("t1_noack", ack_vec(), 4'b0000);
    bus.s_resp.ack = 1'b1;
    bus.s_resp.dat = 32'h1234;
    #1;
    chk("t1_ack", ack_vec(), 4'b0001);
    chk("t1_rdat", bus.m_resp[0].dat, 32'h1234);
    step();
    bus.s_resp.ack = 1'b0;
    #1;
    chk("t1_ack_one", ack_vec(), 4'b0000);
    chk("t1_rel_cs", bus.s_cs, 1'b0);
    chk("t1_rel_gnt", bus.gnt, 4'b0001);
    drop(0);
    step();
    chk("t1_idle_gnt", bus.gnt, 4'b0000);
    chk("t1_idle_busy", bus.busy, 1'b0);

    // Round robin after a fresh reset: 0,1,2 then 3,0
    rst = 1'b0;
    #1 rst = 1'b1;
    step();
    set_req(0, 32'h100, 32'h0);
    set_req(1, 32'h101, 32'h1);
    set_req(2, 32'h102, 32'h2);
    serve(0);
    serve(1);
    serve(2);
    set_req(0, 32'h100, 32'h0);
    set_req(3, 32'h103, 32'h3);
    serve(3);
    serve(0);

    // Ack while idle is ignored; delayed ack; request tracking
    bus.s_resp.ack = 1'b1;
    #1;
    chk("t3_idle_ack", ack_vec(), 4'b0000);
    step();
    chk("t3_idle_busy", bus.busy, 1'b0);
    bus.s_resp.ack = 1'b0;
    set_req(2, 32'h102, 32'h2);
    step();
    chk("t3_gnt", bus.gnt, 4'b0100);
    bus.m_req[2].dat = 32'hABCD;
    step();
    chk("t3_track", bus.s_req.dat, 32'hABCD);
    for (int k = 0; k < 6; k++) begin
      chk("t3_wait_ack", ack_vec(), 4'b0000);
      step();
    end
    chk("t3_still_gnt", bus.gnt, 4'b0100);
    bus.s_resp.ack = 1'b1;
    bus.s_resp.dat = 32'h5A5A;
    #1;
    chk("t3_ack", ack_vec(), 4'b0100);
    chk("t3_other_dat", bus.m_resp[1].dat, 32'h5A5A);
    step();
    bus.s_resp.ack = 1'b0;
    drop(2);
    step();
    chk("t3_done", bus.gnt, 4'b0000);

    // Abort: master 1 drops cyc two cycles into GRANT
    set_req(1, 32'h101, 32'h1);
    step();
    chk("t4_gnt", bus.gnt, 4'b0010);
    step();
    step();
    drop(1);
    #1;
    chk("t4_noack", ack_vec(), 4'b0000);
    step();
    chk("t4_cs", bus.s_cs, 1'b0);
    chk("t4_cyc", bus.s_req.cyc, 1'b0);
    chk("t4_gnt0", bus.gnt, 4'b0000);
    chk("t4_idle", bus.busy, 1'b0);

    // Async reset mid-GRANT; ptr would otherwise favour master 3
    set_req(1, 32'h101, 32'h1);
    step();
    chk("t5_gnt", bus.gnt, 4'b0010);
    step();
    #1 rst = 1'b0;
    #1;
    chk("t5_cs", bus.s_cs, 1'b0);
    chk("t5_gnt0", bus.gnt, 4'b0000);
    chk("t5_cyc", bus.s_req.cyc, 1'b0);
    chk("t5_busy", bus.busy, 1'b0);
    rst = 1'b1;
    set_req(3, 32'h103, 32'h3);
    step();
    chk("t5_restart", bus.gnt, 4'b0010);
    bus.s_resp.ack = 1'b1;
    step();
    bus.s_resp.ack = 1'b0;
    drop(1);
    drop(3);
    step();
    chk("t5_done", bus.gnt, 4'b0000);

    // Unanswered cycle
    set_req(2, 32'h102, 32'h2);
    step();
    chk("t6_gnt", bus.gnt, 4'b0100);
`ifdef SPRITE_ARB_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("t6_no_err_yet", err_vec(), 4'b0000);
    end
    step();
    chk("t6_err", err_vec(), 4'b0100);
    chk("t6_err_noack", ack_vec(), 4'b0000);
    step();
    chk("t6_err_one", err_vec(), 4'b0000);
    chk("t6_cs", bus.s_cs, 1'b0);
    drop(2);
    step();
    chk("t6_done", bus.gnt, 4'b0000);
`else
    repeat (1000) step();
    chk("t6_hold_gnt", bus.gnt, 4'b0100);
    chk("t6_hold_cs", bus.s_cs, 1'b1);
    chk("t6_hold_busy", bus.busy, 1'b1);
    chk("t6_hold_err", err_vec(), 4'b0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
